hamming_enc_engine: RTL and testbench

//  Memory-walking Hamming(16,11) SECDED encoder: the write side of the program-2 decoder.
//  On start, reads N_WORDS 11-bit messages from byte-wide data memory.

---
 rtl/hamming_pkg.sv | 30 +++
 rtl/hamming_enc_core.sv | 11 +
 rtl/hamming_enc_engine.sv | 126 ++++++++++++
 tb/tb_hamming_enc_engine.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(16,11) SECDED definitions: FSM states, default memory map, encoder.
package hamming_pkg;

  localparam int unsigned ENC_N_WORDS  = 15;
  localparam int unsigned ENC_IN_BASE  = 0;
  localparam int unsigned ENC_OUT_BASE = 30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_CAP,
    S_ENC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } enc_state_e;

  // Codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}, even overall parity in p0.
  function automatic logic [15:0] hamming_encode(input logic [11:1] d);
    logic p8, p4, p2, p1, p0;
    p8 = ^d[11:5];
    p4 = ^{d[11:8], d[4:2]};
    p2 = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
    p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
    p0 = ^{d, p8, p4, p2, p1};
    return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational 11-bit message to 16-bit SECDED codeword encoder.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [11:1] i_d,
  output logic [15:0] o_cw
);

  assign o_cw = hamming_encode(i_d);

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-walking Hamming(16,11) encoder: reads N_WORDS messages, writes codewords back.
module hamming_enc_engine
  import hamming_pkg::*;
#(
  parameter int unsigned N_WORDS  = ENC_N_WORDS,
  parameter int unsigned IN_BASE  = ENC_IN_BASE,
  parameter int unsigned OUT_BASE = ENC_OUT_BASE,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata
);

  localparam int unsigned IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

  enc_state_e    r_state, w_next;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_lo;
  logic [2:0]    r_hi;
  logic [15:0]   r_cw;
  logic [15:0]   w_cw;
  logic [AW-1:0] w_ofs;
  logic [AW-1:0] w_rd_base;
  logic [AW-1:0] w_wr_base;
  logic          w_unused_hi;

  // hi byte bits [7:3] carry no message data
  assign w_unused_hi = ^mem_rdata[7:3];

  assign w_ofs     = AW'({r_idx, 1'b0});
  assign w_rd_base = AW'(IN_BASE) + w_ofs;
  assign w_wr_base = AW'(OUT_BASE) + w_ofs;

  hamming_enc_core u_core (
    .i_d  ({r_hi, r_lo}),
    .o_cw (w_cw)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next state and memory-port outputs, all decoded from the current state
  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RD_LO;
      S_RD_LO: begin
        busy      = 1'b1;
        mem_addr  = w_rd_base;
        mem_rd_en = 1'b1;
        w_next    = S_RD_HI;
      end
      S_RD_HI: begin
        busy      = 1'b1;
        mem_addr  = w_rd_base + AW'(1);
        mem_rd_en = 1'b1;
        w_next    = S_CAP;
      end
      S_CAP: begin
        busy   = 1'b1;
        w_next = S_ENC;
      end
      S_ENC: begin
        busy   = 1'b1;
        w_next = S_WR_LO;
      end
      S_WR_LO: begin
        busy      = 1'b1;
        mem_addr  = w_wr_base;
        mem_wr_en = 1'b1;
        mem_wdata = r_cw[7:0];
        w_next    = S_WR_HI;
      end
      S_WR_HI: begin
        busy      = 1'b1;
        mem_addr  = w_wr_base + AW'(1);
        mem_wr_en = 1'b1;
        mem_wdata = r_cw[15:8];
        w_next    = (r_idx == LAST_IDX) ? S_DONE : S_RD_LO;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_RD_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Word index, captured message bytes and registered codeword
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_cw  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) r_idx <= '0;
        S_RD_HI:        r_lo <= mem_rdata;
        S_CAP:          r_hi <= mem_rdata[2:0];
        S_ENC:          r_cw <= w_cw;
        S_WR_HI:        if (r_idx != LAST_IDX) r_idx <= r_idx + IW'(1);
        default:        ;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Directed self-checking bench for hamming_enc_engine with a byte-wide memory model.
module tb_hamming_enc_engine;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy, done;
  logic [7:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_rdata, mem_wdata;

  logic [7:0] mem [0:255];
  bit         wr_flag [0:255];
  logic [7:0] msg_lo [0:14];
  logic [7:0] msg_hi [0:14];
  int         n_assert = 0;
  int         n_fail = 0;
  int         both_cnt = 0;
  int         cyc;

  always #5 clk = ~clk;

  hamming_enc_engine #(.N_WORDS(15), .IN_BASE(0), .OUT_BASE(30), .AW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  // Synchronous-read, write-on-edge memory
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] = mem_wdata;
      wr_flag[mem_addr] = 1'b1;
    end
  end

  always @(negedge clk) if (mem_rd_en && mem_wr_en) both_cnt++;

  // Positional Hamming model: codeword bit j is Hamming position j, bit 0 is overall parity
  function automatic logic [15:0] model_cw(input logic [10:0] d);
    logic [15:0] cw;
    int unsigned k;
    cw = '0;
    k = 0;
    for (int j = 3; j < 16; j++)
      if ((j & (j - 1)) != 0) begin
        cw[j] = d[k];
        k++;
      end
    for (int p = 1; p < 16; p = p * 2)
      for (int j = 3; j < 16; j++)
        if (((j & (j - 1)) != 0) && ((j & p) != 0)) cw[p] = cw[p] ^ cw[j];
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Decoder view: syndrome zero and even overall parity means no error flagged
  function automatic logic decode_clean(input logic [15:0] cw);
    logic [3:0] syn;
    syn = '0;
    for (int j = 1; j < 16; j++) if (cw[j]) syn = syn ^ 4'(j);
    return (syn == 4'd0) && ((^cw) == 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < 15; i++) begin
      mem[2*i]   = msg_lo[i];
      mem[2*i+1] = msg_hi[i];
    end
    for (int a = 0; a < 256; a++) wr_flag[a] = 1'b0;
    for (int a = 30; a < 60; a++) mem[a] = 8'h5A;
  endtask

  // Start a run, optionally re-pulse start after pulse_at edges, return edges until done
  task automatic run(input int pulse_at, output int edges);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("first_busy", {31'd0, busy}, 32'd1);
    chk("first_done_low", {31'd0, done}, 32'd0);
    chk("first_rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("first_addr", {24'd0, mem_addr}, 32'd0);
    edges = 0;
    while (edges < 200) begin
      @(negedge clk) start = (pulse_at != 0) && (edges == pulse_at - 1);
      @(posedge clk);
      edges++;
      #1 if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [15:0] cw, got;
    for (int i = 0; i < 15; i++) begin
      cw  = model_cw({msg_hi[i][2:0], msg_lo[i]});
      got = {mem[31+2*i], mem[30+2*i]};
      chk($sformatf("%s_w%0d", tag, i), {16'd0, got}, {16'd0, cw});
      chk($sformatf("%s_dec%0d", tag, i), {31'd0, decode_clean(got)}, 32'd1);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    mem_rdata = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_rw", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed words 0..4, the rest random with random upper hi bits
    msg_lo[0] = 8'h00; msg_hi[0] = 8'h00;
    msg_lo[1] = 8'h01; msg_hi[1] = 8'h00;
    msg_lo[2] = 8'hFF; msg_hi[2] = 8'h07;
    msg_lo[3] = 8'h00; msg_hi[3] = 8'h04;
    msg_lo[4] = 8'h00; msg_hi[4] = 8'hFC;
    for (int i = 5; i < 15; i++) begin
      msg_lo[i] = 8'($urandom);
      msg_hi[i] = 8'($urandom);
    end
    load_mem();
    run(0, cyc);
    chk("s4_latency", cyc, 32'd90);
    chk("s4_busy_end", {31'd0, busy}, 32'd0);
    chk("hand_000", {mem[31], mem[30]}, 32'h0000);
    chk("hand_001", {mem[33], mem[32]}, 32'h000F);
    chk("hand_7FF", {mem[35], mem[34]}, 32'hFFFF);
    chk("hand_400", {mem[37], mem[36]}, 32'h8117);
    chk("hand_400_hiFC", {mem[39], mem[38]}, 32'h8117);
    check_outputs("s4");

    // Restart from DONE with a stray start mid-run
    load_mem();
    run(20, cyc);
    chk("s5_latency", cyc, 32'd90);
    check_outputs("s5");

    // Reset during WR_HI of word 3
    load_mem();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (23) @(posedge clk);
    #1;
    chk("s6_in_wr_hi", {23'd0, mem_wr_en, mem_addr}, {23'd0, 1'b1, 8'd37});
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_busy", {31'd0, busy}, 32'd0);
    chk("s6_rst_rw", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("s6_rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("s6_rst_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("s6_37_unwritten", {31'd0, wr_flag[37]}, 32'd0);
    chk("s6_36_written", {31'd0, wr_flag[36]}, 32'd1);
    chk("s6_done_low", {31'd0, done}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    load_mem();
    run(0, cyc);
    chk("s6_latency", cyc, 32'd90);
    check_outputs("s6");

    chk("rd_wr_exclusive", both_cnt, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
